pipeline_frontend: RTL and testbench
====================================

# pipeline_frontend

Parametrised fetch/decode/execute front-end for the RISC-V 5-stage core. It owns the PC and the IF/ID and ID/EX pipeline registers, all with valid bits. Beyond a free-running PC, it adds taken-branch redirect with a two-slot flush, load-use hazard detection with bubble insertion, an external freeze, and a saturating bubble counter. The MEMORY and WRITEBACK stages sit downstream and consume the EX_* outputs.

## Interface
- ADDR_W, 10: PC / instruction-memory address width (word index)
- XLEN, 32: instruction width
- PC_STEP, 1: PC increment per fetch
- RESET_PC, 0: PC value after reset
- NOP_INSN, 32'h00000013: encoding loaded into invalid slots (addi x0,x0,0)
- CNT_W, 16: width of BUBBLE_COUNT
- CLK  in  1  system clock, all state updates on posedge
- RST_N  in  1  asynchronous, active-low reset
- INSTRUCTION  in  XLEN  instruction at INSTRUCTION_ADDR, valid combinationally in the same cycle
- EX_BRANCH_TAKEN  in  1  taken branch/jump resolved for the instruction now in EX
- EX_BRANCH_TARGET  in  ADDR_W  redirect address
- EXT_STALL  in  1  freeze the whole front-end (memory wait)
- INSTRUCTION_ADDR  out  ADDR_W  current PC
- ID_INSTRUCTION / ID_PC / ID_VALID  out  XLEN / ADDR_W / 1  IF/ID register
- EX_INSTRUCTION / EX_PC / EX_VALID  out  XLEN / ADDR_W / 1  ID/EX register
- LOAD_USE_STALL  out  1  combinational; hazard detected this cycle
- BUBBLE_COUNT  out  CNT_W  saturating count of bubbles inserted

## Operation
- Reset (async, RST_N=0):
  - PC=RESET_PC.
  - ID_VALID=EX_VALID=0.
  - ID/EX instructions=NOP_INSN.
  - ID/EX PCs=0.
  - BUBBLE_COUNT=0.
- Each posedge, priority order:
  - EXT_STALL=1: all registers hold. Branch and hazard inputs are ignored that cycle; a branch held in EX re-asserts after release.
  - Redirect: EX_BRANCH_TAKEN=1 and EX_VALID=1.
    - PC<=EX_BRANCH_TARGET.
    - ID and EX slots <= invalid/NOP.
    - BUBBLE_COUNT += 2.
    - Overrides load-use.
  - Load-use: LOAD_USE_STALL=1.
    - PC and IF/ID hold.
    - EX slot <= invalid/NOP.
    - BUBBLE_COUNT += 1.
  - Normal advance:
    - PC<=PC+PC_STEP, wrapping mod 2^ADDR_W.
    - IF/ID <= {INSTRUCTION, PC, 1}.
    - ID/EX <= IF/ID.
- LOAD_USE_STALL requires all four conditions:
  - EX_VALID=1.
  - EX opcode[6:0]=7'h03.
  - EX rd[11:7] != 0.
  - ID_VALID=1, and rd equals a source register the ID instruction actually reads.
- rs1 ([19:15]) is read by opcodes 33, 03, 13, 23, 63, 67.
- rs2 ([24:20]) is read by opcodes 33, 23, 63.
- Opcodes 37, 17 and 6F read no source register.
- BUBBLE_COUNT saturates at 2^CNT_W−1. A +2 event at max−1 yields max.
- EX_BRANCH_TAKEN with EX_VALID=0 is ignored.

## Timing
- Fetch-to-ID latency: 1 cycle. Fetch-to-EX: 2 cycles, no stalls.
- First edge after RST_N rises: ID holds the instruction at RESET_PC, with ID_VALID=1.
- Redirect: the target is presented on INSTRUCTION_ADDR the cycle after the taken edge. The target instruction reaches EX 2 cycles after that, giving a 2-bubble penalty.
- Load-use: exactly 1 bubble. The dependent instruction enters EX one cycle after the load leaves EX.
- Reset asserted mid-operation: all state returns to reset values immediately, independent of CLK.

## Test plan
- **Straight-line fetch:** reset, RESET_PC=0, feed distinct words per address. Required:
  - ID_PC goes 0,1,2,… ; EX_PC lags by one cycle.
  - Valids rise at edges 1 and 2.
  - BUBBLE_COUNT=0.
- **Taken branch:** EX holds a valid instruction at PC=5, EX_BRANCH_TAKEN=1, target=0x040. Required:
  - Next cycle INSTRUCTION_ADDR=0x040.
  - ID_VALID=EX_VALID=0.
  - BUBBLE_COUNT=2.
  - The 0x040 instruction appears in EX 2 cycles later.
- **Load-use bubble:**
  - lw x5 (0x0002A283) in EX, add x6,x5,x1 (0x00128333) in ID. Required: LOAD_USE_STALL=1; next edge EX_VALID=0; ID holds the add; the add reaches EX one edge later.
  - Repeat with rd=x0 and with lui x5 in ID. Required: no stall.
- **Simultaneous events:**
  - Branch taken and load-use in the same cycle. Required: redirect wins; count +2, not +3.
  - EXT_STALL=1 with branch taken. Required: nothing changes until stall releases, then redirect occurs.
- **Wrap and saturation:**
  - PC=0x3FF advances. Required: PC=0x000.
  - CNT_W=4, force repeated redirects. Required: count stops at 15, including the 14→15 case.
- **Async reset mid-stream:** drop RST_N between clock edges. Required: outputs return to reset values immediately; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/pipeline_frontend.sv
// -----------------------------------------------------------------------------
// pipeline_frontend
//
// Fetch/decode/execute front-end of the 5-stage RISC-V core. Owns the PC and
// the IF/ID and ID/EX pipeline registers, each slot carrying a valid bit.
// It handles three events:
//   - taken-branch redirect from EX, which flushes two slots;
//   - load-use hazard, which inserts one bubble into EX;
//   - external freeze, which holds every register.
// It also keeps a saturating count of the bubbles it has inserted.
//
// Ports
//   clk_i                system clock, rising-edge active
//   rst_ni               asynchronous active-low reset
//   instruction_i        instruction word at instruction_addr_o (same cycle)
//   ex_branch_taken_i    branch/jump resolved taken for the EX instruction
//   ex_branch_target_i   redirect address
//   ext_stall_i          freeze the whole front-end
//   instruction_addr_o   current PC
//   id_instruction_o     IF/ID register: instruction
//   id_pc_o              IF/ID register: PC
//   id_valid_o           IF/ID register: valid
//   ex_instruction_o     ID/EX register: instruction
//   ex_pc_o              ID/EX register: PC
//   ex_valid_o           ID/EX register: valid
//   load_use_stall_o     combinational load-use hazard indication
//   bubble_count_o       saturating count of inserted bubbles
// -----------------------------------------------------------------------------
module pipeline_frontend #(
    parameter int                ADDR_W   = 10,
    parameter int                XLEN     = 32,
    parameter int                PC_STEP  = 1,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [XLEN-1:0]   NOP_INSN = 32'h00000013,
    parameter int                CNT_W    = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [XLEN-1:0]   instruction_i,
    input  logic              ex_branch_taken_i,
    input  logic [ADDR_W-1:0] ex_branch_target_i,
    input  logic              ext_stall_i,
    output logic [ADDR_W-1:0] instruction_addr_o,
    output logic [XLEN-1:0]   id_instruction_o,
    output logic [ADDR_W-1:0] id_pc_o,
    output logic              id_valid_o,
    output logic [XLEN-1:0]   ex_instruction_o,
    output logic [ADDR_W-1:0] ex_pc_o,
    output logic              ex_valid_o,
    output logic              load_use_stall_o,
    output logic [CNT_W-1:0]  bubble_count_o
);

    localparam logic [6:0]   OP_LOAD   = 7'h03;
    localparam logic [6:0]   OP_OPIMM  = 7'h13;
    localparam logic [6:0]   OP_STORE  = 7'h23;
    localparam logic [6:0]   OP_OP     = 7'h33;
    localparam logic [6:0]   OP_BRANCH = 7'h63;
    localparam logic [6:0]   OP_JALR   = 7'h67;
    localparam logic [CNT_W:0] CNT_MAX = {1'b0, {CNT_W{1'b1}}};

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [XLEN-1:0]   idInsn_q, idInsn_d;
    logic [ADDR_W-1:0] idPc_q, idPc_d;
    logic              idValid_q, idValid_d;
    logic [XLEN-1:0]   exInsn_q, exInsn_d;
    logic [ADDR_W-1:0] exPc_q, exPc_d;
    logic              exValid_q, exValid_d;
    logic [CNT_W-1:0]  bubbleCnt_q, bubbleCnt_d;

    logic       redirect;
    logic       loadUse;
    logic       idUsesRs1;
    logic       idUsesRs2;
    logic [1:0] bubbleInc;
    logic [CNT_W:0] cntSum;

    // Decode which source registers the ID instruction actually reads, so
    // that U/J-type encodings whose immediate bits alias rs1/rs2 never stall.
    always_comb begin
        idUsesRs1 = 1'b0;
        idUsesRs2 = 1'b0;
        case (idInsn_q[6:0])
            OP_OP, OP_STORE, OP_BRANCH: begin
                idUsesRs1 = 1'b1;
                idUsesRs2 = 1'b1;
            end
            OP_LOAD, OP_OPIMM, OP_JALR: idUsesRs1 = 1'b1;
            default: ;
        endcase
    end

    // A load in EX whose non-zero destination feeds the ID instruction.
    assign loadUse = exValid_q && (exInsn_q[6:0] == OP_LOAD) && (exInsn_q[11:7] != 5'd0)
                     && idValid_q
                     && ((idUsesRs1 && (idInsn_q[19:15] == exInsn_q[11:7]))
                      || (idUsesRs2 && (idInsn_q[24:20] == exInsn_q[11:7])));

    assign redirect = ex_branch_taken_i && exValid_q;

    // Next-state selection; the freeze beats redirect, which beats load-use.
    always_comb begin
        pc_d      = pc_q;
        idInsn_d  = idInsn_q;
        idPc_d    = idPc_q;
        idValid_d = idValid_q;
        exInsn_d  = exInsn_q;
        exPc_d    = exPc_q;
        exValid_d = exValid_q;
        bubbleInc = 2'd0;
        if (!ext_stall_i) begin
            if (redirect) begin
                pc_d      = ex_branch_target_i;
                idInsn_d  = NOP_INSN;
                idPc_d    = '0;
                idValid_d = 1'b0;
                exInsn_d  = NOP_INSN;
                exPc_d    = '0;
                exValid_d = 1'b0;
                bubbleInc = 2'd2;
            end else if (loadUse) begin
                exInsn_d  = NOP_INSN;
                exPc_d    = '0;
                exValid_d = 1'b0;
                bubbleInc = 2'd1;
            end else begin
                pc_d      = pc_q + ADDR_W'(PC_STEP);
                idInsn_d  = instruction_i;
                idPc_d    = pc_q;
                idValid_d = 1'b1;
                exInsn_d  = idInsn_q;
                exPc_d    = idPc_q;
                exValid_d = idValid_q;
            end
        end
    end

    // One extra bit of headroom lets the saturation test catch max-1 plus 2.
    always_comb begin
        cntSum      = {1'b0, bubbleCnt_q} + (CNT_W+1)'(bubbleInc);
        bubbleCnt_d = (cntSum > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : cntSum[CNT_W-1:0];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q        <= RESET_PC;
            idInsn_q    <= NOP_INSN;
            idPc_q      <= '0;
            idValid_q   <= 1'b0;
            exInsn_q    <= NOP_INSN;
            exPc_q      <= '0;
            exValid_q   <= 1'b0;
            bubbleCnt_q <= '0;
        end else begin
            pc_q        <= pc_d;
            idInsn_q    <= idInsn_d;
            idPc_q      <= idPc_d;
            idValid_q   <= idValid_d;
            exInsn_q    <= exInsn_d;
            exPc_q      <= exPc_d;
            exValid_q   <= exValid_d;
            bubbleCnt_q <= bubbleCnt_d;
        end
    end

    assign instruction_addr_o = pc_q;
    assign id_instruction_o   = idInsn_q;
    assign id_pc_o            = idPc_q;
    assign id_valid_o         = idValid_q;
    assign ex_instruction_o   = exInsn_q;
    assign ex_pc_o            = exPc_q;
    assign ex_valid_o         = exValid_q;
    assign load_use_stall_o   = loadUse;
    assign bubble_count_o     = bubbleCnt_q;

endmodule

// File: tb/tb_pipeline_frontend.sv
// Directed testbench for pipeline_frontend. The DUT is built with a 4-bit
// bubble counter so that saturation is reachable in a short run.
module tb_pipeline_frontend;

   localparam int ADDR_W = 10;
   localparam int XLEN   = 32;
   localparam int CNT_W  = 4;
   localparam logic [31:0] NOP = 32'h00000013;

   logic              clk;
   logic              rstN;
   logic [XLEN-1:0]   instruction;
   logic              branchTaken;
   logic [ADDR_W-1:0] branchTarget;
   logic              extStall;
   logic [ADDR_W-1:0] instructionAddr;
   logic [XLEN-1:0]   idInstruction;
   logic [ADDR_W-1:0] idPc;
   logic              idValid;
   logic [XLEN-1:0]   exInstruction;
   logic [ADDR_W-1:0] exPc;
   logic              exValid;
   logic              loadUseStall;
   logic [CNT_W-1:0]  bubbleCount;

   int testsRun    = 0;
   int testsFailed = 0;

   pipeline_frontend #(
      .ADDR_W  (ADDR_W),
      .XLEN    (XLEN),
      .PC_STEP (1),
      .RESET_PC('0),
      .NOP_INSN(NOP),
      .CNT_W   (CNT_W)
   ) dut (
      .clk_i             (clk),
      .rst_ni            (rstN),
      .instruction_i     (instruction),
      .ex_branch_taken_i (branchTaken),
      .ex_branch_target_i(branchTarget),
      .ext_stall_i       (extStall),
      .instruction_addr_o(instructionAddr),
      .id_instruction_o  (idInstruction),
      .id_pc_o           (idPc),
      .id_valid_o        (idValid),
      .ex_instruction_o  (exInstruction),
      .ex_pc_o           (exPc),
      .ex_valid_o        (exValid),
      .load_use_stall_o  (loadUseStall),
      .bubble_count_o    (bubbleCount)
   );

   // Free-running 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Instruction memory: filler words are addi x0,x0,<addr>, which never
   // create a hazard; a few addresses hold hand-placed hazard scenarios.
   function automatic logic [31:0] imem(input logic [ADDR_W-1:0] a);
      case (a)
         10'h041: return 32'h0002A283;  // lw  x5,0(x5)
         10'h042: return 32'h00128333;  // add x6,x5,x1
         10'h044: return 32'h0002A003;  // lw  x0,0(x5)
         10'h045: return 32'h00100333;  // add x6,x0,x1
         10'h046: return 32'h0002A283;  // lw  x5,0(x5)
         10'h047: return 32'h000282B7;  // lui x5 with bits[19:15]=5
         10'h048: return 32'h0002A283;  // lw  x5,0(x5)
         10'h049: return 32'h00128333;  // add x6,x5,x1
         10'h050: return 32'h0002A283;  // lw  x5,0(x5)
         10'h051: return 32'h00128333;  // add x6,x5,x1
         default: return {2'b00, a, 20'h00013};
      endcase
   endfunction

   // Memory answers combinationally from the current PC.
   assign instruction = imem(instructionAddr);

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Drive the control inputs between edges.
   task automatic applyStimulus(input logic taken, input logic [ADDR_W-1:0] target,
                                input logic stall);
      branchTaken  = taken;
      branchTarget = target;
      extStall     = stall;
   endtask

   // Advance one rising edge and settle just after it.
   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Main directed sequence; edge numbers in comments count from reset release.
   initial begin
      rstN = 1'b0;
      applyStimulus(1'b0, '0, 1'b0);
      #12;
      checkOutput("rst_pc",      32'(instructionAddr), 32'h0);
      checkOutput("rst_idvalid", 32'(idValid), 32'h0);
      checkOutput("rst_exvalid", 32'(exValid), 32'h0);
      checkOutput("rst_idinsn",  idInstruction, NOP);
      checkOutput("rst_exinsn",  exInstruction, NOP);
      checkOutput("rst_count",   32'(bubbleCount), 32'h0);
      rstN = 1'b1;

      // Straight-line fetch, edges 1..7.
      tick();
      checkOutput("e1_idpc",    32'(idPc), 32'h0);
      checkOutput("e1_idvalid", 32'(idValid), 32'h1);
      checkOutput("e1_idinsn",  idInstruction, imem(10'h000));
      checkOutput("e1_exvalid", 32'(exValid), 32'h0);
      checkOutput("e1_pc",      32'(instructionAddr), 32'h1);
      tick();
      checkOutput("e2_idpc",    32'(idPc), 32'h1);
      checkOutput("e2_expc",    32'(exPc), 32'h0);
      checkOutput("e2_exvalid", 32'(exValid), 32'h1);
      checkOutput("e2_exinsn",  exInstruction, imem(10'h000));
      for (int e = 3; e <= 7; e++) begin
         tick();
         checkOutput("seq_idpc", 32'(idPc), 32'(e - 1));
         checkOutput("seq_expc", 32'(exPc), 32'(e - 2));
      end
      checkOutput("seq_count", 32'(bubbleCount), 32'h0);

      // Taken branch from EX (PC 5) to 0x040.
      checkOutput("br_expc_pre", 32'(exPc), 32'h5);
      applyStimulus(1'b1, 10'h040, 1'b0);
      tick();
      applyStimulus(1'b0, '0, 1'b0);
      checkOutput("br_pc",      32'(instructionAddr), 32'h040);
      checkOutput("br_idvalid", 32'(idValid), 32'h0);
      checkOutput("br_exvalid", 32'(exValid), 32'h0);
      checkOutput("br_count",   32'(bubbleCount), 32'h2);
      tick(2);
      checkOutput("br_tgt_expc",  32'(exPc), 32'h040);
      checkOutput("br_tgt_exval", 32'(exValid), 32'h1);
      checkOutput("br_tgt_insn",  exInstruction, imem(10'h040));

      // Load-use: lw x5 in EX, add reading x5 in ID.
      tick();
      checkOutput("lu_stall",    32'(loadUseStall), 32'h1);
      tick();
      checkOutput("lu_exvalid",  32'(exValid), 32'h0);
      checkOutput("lu_idhold",   idInstruction, 32'h00128333);
      checkOutput("lu_pchold",   32'(instructionAddr), 32'h043);
      checkOutput("lu_count",    32'(bubbleCount), 32'h3);
      tick();
      checkOutput("lu_add_ex",   exInstruction, 32'h00128333);
      checkOutput("lu_add_expc", 32'(exPc), 32'h042);

      // rd=x0 load followed by reader of x0: no hazard.
      tick(2);
      checkOutput("lu_x0_exinsn", exInstruction, 32'h0002A003);
      checkOutput("lu_x0_stall",  32'(loadUseStall), 32'h0);
      tick();
      checkOutput("lu_x0_advance", 32'(exPc), 32'h045);

      // lui whose immediate aliases rs1=x5: no hazard.
      tick();
      checkOutput("lu_lui_exinsn", exInstruction, 32'h0002A283);
      checkOutput("lu_lui_stall",  32'(loadUseStall), 32'h0);
      tick();
      checkOutput("lu_lui_advance", 32'(exPc), 32'h047);
      checkOutput("lu_lui_exvalid", 32'(exValid), 32'h1);

      // Branch and load-use together: redirect wins, +2 only.
      tick();
      checkOutput("sim_stall", 32'(loadUseStall), 32'h1);
      applyStimulus(1'b1, 10'h100, 1'b0);
      tick();
      applyStimulus(1'b0, '0, 1'b0);
      checkOutput("sim_pc",      32'(instructionAddr), 32'h100);
      checkOutput("sim_count",   32'(bubbleCount), 32'h5);
      checkOutput("sim_idvalid", 32'(idValid), 32'h0);

      // Freeze with a taken branch held in EX.
      tick(2);
      applyStimulus(1'b1, 10'h200, 1'b1);
      tick(2);
      checkOutput("frz_pc",    32'(instructionAddr), 32'h102);
      checkOutput("frz_idpc",  32'(idPc), 32'h101);
      checkOutput("frz_expc",  32'(exPc), 32'h100);
      checkOutput("frz_count", 32'(bubbleCount), 32'h5);
      applyStimulus(1'b1, 10'h200, 1'b0);
      tick();
      applyStimulus(1'b0, '0, 1'b0);
      checkOutput("frz_rel_pc",    32'(instructionAddr), 32'h200);
      checkOutput("frz_rel_count", 32'(bubbleCount), 32'h7);

      // PC wrap from 0x3FF.
      tick(2);
      applyStimulus(1'b1, 10'h3FF, 1'b0);
      tick();
      applyStimulus(1'b0, '0, 1'b0);
      checkOutput("wrap_pre",   32'(instructionAddr), 32'h3FF);
      tick();
      checkOutput("wrap_pc",    32'(instructionAddr), 32'h000);
      checkOutput("wrap_idpc",  32'(idPc), 32'h3FF);
      checkOutput("wrap_count", 32'(bubbleCount), 32'h9);

      // Steer to a load-use pair so the count becomes even, then saturate.
      tick();
      applyStimulus(1'b1, 10'h050, 1'b0);
      tick();
      applyStimulus(1'b0, '0, 1'b0);
      checkOutput("sat_c11", 32'(bubbleCount), 32'd11);
      tick(2);
      checkOutput("sat_lu_stall", 32'(loadUseStall), 32'h1);
      tick();
      checkOutput("sat_c12", 32'(bubbleCount), 32'd12);
      tick();
      applyStimulus(1'b1, 10'h060, 1'b0);
      tick();
      checkOutput("sat_c14", 32'(bubbleCount), 32'd14);
      tick(3);
      checkOutput("sat_c14to15", 32'(bubbleCount), 32'd15);
      tick(3);
      checkOutput("sat_hold15", 32'(bubbleCount), 32'd15);
      checkOutput("sat_pc",     32'(instructionAddr), 32'h060);
      applyStimulus(1'b0, '0, 1'b0);
      tick(2);

      // Asynchronous reset between edges, then restart.
      #2;
      rstN = 1'b0;
      #1;
      checkOutput("arst_pc",      32'(instructionAddr), 32'h0);
      checkOutput("arst_idvalid", 32'(idValid), 32'h0);
      checkOutput("arst_exvalid", 32'(exValid), 32'h0);
      checkOutput("arst_expc",    32'(exPc), 32'h0);
      checkOutput("arst_idinsn",  idInstruction, NOP);
      checkOutput("arst_count",   32'(bubbleCount), 32'h0);
      #3;
      rstN = 1'b1;
      tick();
      checkOutput("arst_e1_idpc",  32'(idPc), 32'h0);
      checkOutput("arst_e1_valid", 32'(idValid), 32'h1);
      checkOutput("arst_e1_pc",    32'(instructionAddr), 32'h1);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
